// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
// States, redirect-source encoding, default reset vector and step,
// plus small alignment helpers used when PC_ALIGN_CHECK_EN is defined.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JREG   = 2'd3
    } redir_sel_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP_BYTES   = 32'd4;

    // Clear the byte-offset bits so the address lands on a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when the address is not on a word boundary.
    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target selection: priority JumpReg > Jump > Branch.
// Branch target is base + pre-shifted offset (wraps mod 2^32),
// jump target keeps the top nibble of the delay-slot address.
module pc_target_sel
    import pc_pkg::*;
(
    input  logic        branch,
    input  logic [31:0] branch_offset,
    input  logic [31:0] branch_base,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] target,
    output redir_sel_t  sel
);

    logic [31:0] branch_sum_s;
    logic [31:0] jump_addr_s;

    assign branch_sum_s = branch_base + branch_offset;
    assign jump_addr_s  = {branch_base[31:28], jump_index, 2'b00};

    // Priority-encode the redirect source and pick its target address.
    always_comb begin
        sel    = SEL_NONE;
        target = branch_sum_s;
        if (jump_reg) begin
            sel    = SEL_JREG;
            target = reg_target;
        end else if (jump) begin
            sel    = SEL_JUMP;
            target = jump_addr_s;
        end else if (branch) begin
            sel    = SEL_BRANCH;
            target = branch_sum_s;
        end else begin
            sel    = SEL_NONE;
            target = branch_sum_s;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: owns the PC, the pending-redirect register and
// the BOOT/RUN/PEND control. A redirect that cannot be accepted this
// cycle is parked and applied at the next accepted fetch, unless a newer
// redirect arrives first.
// Optional: define PC_ALIGN_CHECK_EN to force captured targets onto word
// boundaries and pulse AddrError for one cycle on a misaligned capture.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = PC_STEP_BYTES
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        Stall,
    input  logic        FetchReady,
    input  logic        Branch,
    input  logic [31:0] BranchOffset,
    input  logic [31:0] BranchBase,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Redirecting,
    output logic        AddrError
);

    pc_state_t   state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_r;
    logic        fetch_valid_r;
    logic        redirecting_r;

    logic [31:0] target_s;
    redir_sel_t  sel_s;
    logic        req_s;
    logic        adv_s;
    logic [31:0] cap_s;
    logic [31:0] pc_plus_s;

    pc_target_sel u_target_sel (
        .branch        (Branch),
        .branch_offset (BranchOffset),
        .branch_base   (BranchBase),
        .jump          (Jump),
        .jump_index    (JumpIndex),
        .jump_reg      (JumpReg),
        .reg_target    (RegTarget),
        .target        (target_s),
        .sel           (sel_s)
    );

    assign req_s     = (sel_s != SEL_NONE);
    assign adv_s     = fetch_valid_r & FetchReady & ~Stall;
    assign pc_plus_s = pc_r + PC_STEP;

`ifdef PC_ALIGN_CHECK_EN
    logic addr_err_r;

    assign cap_s = word_align(target_s);

    // One-cycle flag after any misaligned target is captured outside BOOT.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_err_r <= 1'b0;
        end else begin
            addr_err_r <= (state_r != BOOT) & req_s & misaligned(target_s);
        end
    end

    assign AddrError = addr_err_r;
`else
    assign cap_s     = target_s;
    assign AddrError = 1'b0;
`endif

    // Fetch FSM with the PC and pending-redirect registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r       <= BOOT;
            pc_r          <= RESET_VECTOR;
            pend_r        <= 32'h0000_0000;
            fetch_valid_r <= 1'b0;
            redirecting_r <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                    redirecting_r <= 1'b0;
                end
                RUN: begin
                    if (adv_s) begin
                        pc_r <= req_s ? cap_s : pc_plus_s;
                    end else if (req_s) begin
                        pend_r        <= cap_s;
                        state_r       <= PEND;
                        redirecting_r <= 1'b1;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                PEND: begin
                    if (adv_s) begin
                        // A fresh request overrides the parked target.
                        pc_r          <= req_s ? cap_s : pend_r;
                        state_r       <= RUN;
                        redirecting_r <= 1'b0;
                    end else if (req_s) begin
                        pend_r <= cap_s;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                default: begin
                    state_r       <= BOOT;
                    fetch_valid_r <= 1'b0;
                    redirecting_r <= 1'b0;
                end
            endcase
        end
    end

    assign PC          = pc_r;
    assign PCPlus4     = pc_plus_s;
    assign FetchValid  = fetch_valid_r;
    assign Redirecting = redirecting_r;

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage for the fetch path.
- Consumes the branch offset already left-shifted by 2 in the decode path, together with jump and jump-register targets.
- Owns the PC register and selects the next fetch address.
- Uses a valid/ready-style handshake with instruction memory. A redirect that arrives while the current fetch is not yet accepted is held pending and applied at the next accepted fetch.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Stall  input  1  pipeline hold; the PC does not advance while high.
- FetchReady  input  1  instruction memory accepts the current PC this cycle.
- Branch  input  1  taken conditional branch resolved in decode.
- BranchOffset  input  32  sign-extended immediate, already shifted left by 2.
- BranchBase  input  32  address of the delay-slot instruction (branch PC + 4).
- Jump  input  1  J/JAL redirect.
- JumpIndex  input  26  instr_index field.
- JumpReg  input  1  JR/JALR redirect.
- RegTarget  input  32  register operand for JumpReg.
- PC  output  32  current fetch address, registered.
- PCPlus4  output  32  PC + PC_STEP, combinational from the PC register.
- FetchValid  output  1  PC is a valid fetch request.
- Redirecting  output  1  redirect is pending (state PEND), registered.
- AddrError  output  1  misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (async, nReset=0): PC=RESET_VECTOR, state=BOOT, FetchValid=0, Redirecting=0, AddrError=0, pending register=0.
- Advance condition: adv = FetchValid & FetchReady & ~Stall.
- Redirect request: req = Branch | Jump | JumpReg.
- Target priority: JumpReg > Jump > Branch.
  - JumpReg target = RegTarget.
  - Jump target = {BranchBase[31:28], JumpIndex, 2'b00}.
  - Branch target = BranchBase + BranchOffset, modulo 2^32; carry discarded.
- Sequential wrap: PC + PC_STEP wraps modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.
- State BOOT:
  - FetchValid=0.
  - Next cycle goes to RUN unconditionally; PC unchanged; inputs ignored.
- State RUN (FetchValid=1):
  - adv & req: PC <= target; stay in RUN.
  - adv & ~req: PC <= PC + PC_STEP.
  - ~adv & req: pending <= target; go to PEND; Redirecting=1 from the next cycle. PC unchanged.
  - ~adv & ~req: hold.
- State PEND (FetchValid=1, Redirecting=1):
  - adv & ~req: PC <= pending; go to RUN.
  - adv & req: PC <= new target (the new request wins over pending); go to RUN.
  - ~adv & req: pending <= new target; stay in PEND.
  - ~adv & ~req: hold.
- Latency: a redirect accepted with adv is visible on PC the next cycle. A redirect without adv is visible on PC one cycle after the first subsequent adv.
- Stall has priority over FetchReady: no PC change while Stall=1. Redirect capture into pending still occurs during Stall.
- Reset mid-operation: pending is discarded and the block returns to BOOT.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - When a target is captured (into PC or into pending) with target[1:0] != 0, AddrError is high for exactly one cycle, the cycle after capture.
  - The captured value has [1:0] forced to 2'b00.
- Undefined:
  - AddrError is tied to 0.
  - Targets are captured unmodified.

Decomposition:
- Package pc_pkg:
  - pc_state_t enum {BOOT, RUN, PEND}.
  - redir_sel_t enum {SEL_NONE, SEL_BRANCH, SEL_JUMP, SEL_JREG}.
  - Default RESET_VECTOR constant.
  - PC_STEP constant.
- Sub-module pc_target_sel: combinational priority encode, branch adder and jump concatenation, producing the target and redir_sel_t. The top level holds the FSM, the PC register and the pending register.

Test Plan:
- Reset with RESET_VECTOR default: PC=32'hBFC0_0000, FetchValid=0 in BOOT. Then FetchValid=1 with FetchReady=1, Stall=0 -> PC 32'hBFC0_0004, 32'hBFC0_0008 on successive cycles.
- Branch=1, BranchBase=32'h0000_1004, BranchOffset=32'hFFFF_FFF8, FetchReady=1 -> PC=32'h0000_0FFC next cycle.
- Jump=1, JumpIndex=26'h0000040, BranchBase=32'h9000_0000 with FetchReady=0 for 3 cycles:
  - Redirecting=1, PC held.
  - FetchReady=1 -> PC=32'h9000_0100, Redirecting=0.
- Branch, Jump and JumpReg together, RegTarget=32'h0000_2000, adv=1 -> PC=32'h0000_2000. A new JumpReg in PEND replaces the pending Jump target.
- PC=32'hFFFF_FFFC, adv=1, no redirect -> PC=32'h0000_0000. Stall=1 for 2 cycles -> PC unchanged.
- With PC_ALIGN_CHECK_EN: JumpReg, RegTarget=32'h0000_3002 -> PC=32'h0000_3000, one-cycle AddrError pulse. Without the macro: PC=32'h0000_3002, AddrError=0.
